// File: rtl/sprite_palette_ram_pkg.sv
// Shared types, boot constants and sizing helpers for the sprite palette RAM.
// Colour words are {R,G,B}; the boot tables are expressed at 4 bits per channel.
package sprite_palette_ram_pkg;

    localparam int PAL_CH_W = 4;

    typedef struct packed {
        logic [PAL_CH_W-1:0] r;
        logic [PAL_CH_W-1:0] g;
        logic [PAL_CH_W-1:0] b;
    } rgb_t;

    localparam rgb_t DEFAULT_RGB = 12'h6AF;
    localparam int   BOOT_FIRST  = 1;
    localparam int   BOOT_LAST   = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Width of a select field that must stay at least one bit wide.
    function automatic int sel_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic logic boot_hit(input int e);
        return (e >= BOOT_FIRST) && (e <= BOOT_LAST);
    endfunction

    function automatic rgb_t boot_rgb(input int e);
        rgb_t c;
        case (e)
            1:       c = 12'h520;
            2:       c = 12'hFFF;
            3:       c = 12'h940;
            4:       c = 12'h000;
            default: c = DEFAULT_RGB;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sprite_palette_ram_if.sv
// Write, lookup, colour-cycle and result signals of the sprite palette RAM.
// The renderer side drives through master; the palette itself uses slave.
interface sprite_palette_ram_if
    import sprite_palette_ram_pkg::*;
#(
    parameter int IDX_W     = 4,
    parameter int CH_W      = 4,
    parameter int NUM_BANKS = 4
) ();

    localparam int BK_W = sel_w(NUM_BANKS);

    logic              wr_en;
    logic [BK_W-1:0]   wr_bank;
    logic [IDX_W-1:0]  wr_idx;
    logic [3*CH_W-1:0] wr_rgb;

    logic              rd_valid;
    logic [BK_W-1:0]   rd_bank;
    logic [IDX_W-1:0]  rd_idx;

    logic              frame_tick;
    logic              cyc_en;
    logic [IDX_W-1:0]  cyc_lo;
    logic [IDX_W-1:0]  cyc_hi;
    logic              transp_en;

    logic              out_valid;
    logic [CH_W-1:0]   red;
    logic [CH_W-1:0]   green;
    logic [CH_W-1:0]   blue;
    logic              transparent;

    modport master (
        output wr_en, wr_bank, wr_idx, wr_rgb,
        output rd_valid, rd_bank, rd_idx,
        output frame_tick, cyc_en, cyc_lo, cyc_hi, transp_en,
        input  out_valid, red, green, blue, transparent
    );

    modport slave (
        input  wr_en, wr_bank, wr_idx, wr_rgb,
        input  rd_valid, rd_bank, rd_idx,
        input  frame_tick, cyc_en, cyc_lo, cyc_hi, transp_en,
        output out_valid, red, green, blue, transparent
    );

endinterface

// File: rtl/sprite_palette_ram_cycle_ctrl.sv
// Colour-cycling control: frame-tick divider, rotating offset and index remap.
// The remap is combinational so a lookup sees the offset as of its own cycle.
module palette_cycle_ctrl
    import sprite_palette_ram_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int CYC_DIV = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_frame_tick,
    input  logic             i_cyc_en,
    input  logic [IDX_W-1:0] i_cyc_lo,
    input  logic [IDX_W-1:0] i_cyc_hi,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [IDX_W-1:0] o_eff_idx
);

    localparam int               DIV_W    = sel_w(CYC_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CYC_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [IDX_W-1:0] r_off;

    logic             w_active;
    logic             w_in_rng;
    logic [IDX_W:0]   w_lo;
    logic [IDX_W:0]   w_span;
    logic [IDX_W:0]   w_mod_n;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W:0]   w_rot;
    logic [IDX_W:0]   w_eff;

    assign w_active = i_cyc_en && (i_cyc_lo < i_cyc_hi);
    assign w_lo     = {1'b0, i_cyc_lo};
    assign w_span   = {1'b0, i_cyc_hi} - w_lo;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= '0;
            r_off <= '0;
        end else if (!w_active) begin
            r_div <= '0;
            r_off <= '0;
        end else if (i_frame_tick) begin
            if (r_div == DIV_LAST) begin
                r_div <= '0;
                // A stale offset from a wider range restarts at zero.
                if ({1'b0, r_off} >= w_span) r_off <= '0;
                else                         r_off <= r_off + IDX_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign w_in_rng = w_active
                   && (i_rd_idx >= i_cyc_lo)
                   && (i_rd_idx <= i_cyc_hi);

    // Divisor forced to 1 outside the range so the modulo never sees zero.
    assign w_mod_n = w_in_rng ? (w_span + (IDX_W+1)'(1)) : (IDX_W+1)'(1);
    assign w_sum   = ({1'b0, i_rd_idx} - w_lo) + {1'b0, r_off};
    assign w_rot   = w_sum % w_mod_n;
    assign w_eff   = w_lo + w_rot;

    assign o_eff_idx = w_in_rng ? w_eff[IDX_W-1:0] : i_rd_idx;

endmodule

// File: rtl/sprite_palette_ram.sv
// Banked sprite palette with colour cycling, transparency key and 1-cycle lookup.
// Storage resets to the boot palette; same-entry read/write returns the old value.
module sprite_palette_ram
    import sprite_palette_ram_pkg::*;
#(
    parameter int IDX_W     = 4,
    parameter int CH_W      = 4,
    parameter int NUM_BANKS = 4,
    parameter int CYC_DIV   = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    sprite_palette_ram_if.slave  bus
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int RGB_W   = 3 * CH_W;
    localparam int BK_W    = sel_w(NUM_BANKS);

    localparam logic [BK_W-1:0] BK_MASK = BK_W'(NUM_BANKS - 1);

    function automatic logic [RGB_W-1:0] to_word(input rgb_t c);
        return {CH_W'(c.r), CH_W'(c.g), CH_W'(c.b)};
    endfunction

    logic [RGB_W-1:0] r_mem [NUM_BANKS][ENTRIES];
    logic             r_valid;
    logic [RGB_W-1:0] r_rgb;
    logic             r_transp;

    logic [IDX_W-1:0] w_eff_idx;
    logic [BK_W-1:0]  w_wr_bank;
    logic [BK_W-1:0]  w_rd_bank;
    logic [RGB_W-1:0] w_rd_word;

    assign w_wr_bank = bus.wr_bank & BK_MASK;
    assign w_rd_bank = bus.rd_bank & BK_MASK;

    palette_cycle_ctrl #(
        .IDX_W   (IDX_W),
        .CYC_DIV (CYC_DIV)
    ) u_cycle (
        .i_clk        (Clk),
        .i_rst        (Reset),
        .i_frame_tick (bus.frame_tick),
        .i_cyc_en     (bus.cyc_en),
        .i_cyc_lo     (bus.cyc_lo),
        .i_cyc_hi     (bus.cyc_hi),
        .i_rd_idx     (bus.rd_idx),
        .o_eff_idx    (w_eff_idx)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int e = 0; e < ENTRIES; e++) begin
                    if (b == 0 && boot_hit(e)) r_mem[b][e] <= to_word(boot_rgb(e));
                    else                       r_mem[b][e] <= to_word(DEFAULT_RGB);
                end
            end
        end else if (bus.wr_en) begin
            r_mem[w_wr_bank][bus.wr_idx] <= bus.wr_rgb;
        end
    end

    assign w_rd_word = r_mem[w_rd_bank][w_eff_idx];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_valid  <= 1'b0;
            r_rgb    <= '0;
            r_transp <= 1'b0;
        end else begin
            r_valid <= bus.rd_valid;
            if (bus.rd_valid) begin
                r_rgb    <= w_rd_word;
                r_transp <= bus.transp_en && (bus.rd_idx == '0);
            end
        end
    end

    assign bus.out_valid   = r_valid;
    assign bus.red         = r_rgb[RGB_W-1 -: CH_W];
    assign bus.green       = r_rgb[2*CH_W-1 -: CH_W];
    assign bus.blue        = r_rgb[CH_W-1:0];
    assign bus.transparent = r_transp;

endmodule

// File: tb/tb_sprite_palette_ram.sv
// Bench for sprite_palette_ram: directed scenarios then random traffic,
// all checked against an array-based palette model.
module tb_sprite_palette_ram;
    import sprite_palette_ram_pkg::*;

    localparam int IDX_W   = 4;
    localparam int CH_W    = 4;
    localparam int NB      = 4;
    localparam int CYC_DIV = 2;
    localparam int NE      = 16;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    sprite_palette_ram_if #(
        .IDX_W(IDX_W), .CH_W(CH_W), .NUM_BANKS(NB)
    ) bus ();

    sprite_palette_ram #(
        .IDX_W(IDX_W), .CH_W(CH_W), .NUM_BANKS(NB), .CYC_DIV(CYC_DIV)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [11:0] m_mem [NB][NE];
    int          m_ticks;
    int          m_off;
    logic        m_valid;
    logic [11:0] m_rgb;
    logic        m_tr;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++)
            for (int e = 0; e < NE; e++)
                m_mem[b][e] = 12'h6AF;
        m_mem[0][1] = 12'h520;
        m_mem[0][2] = 12'hFFF;
        m_mem[0][3] = 12'h940;
        m_mem[0][4] = 12'h000;
        m_ticks = 0;
        m_off   = 0;
        m_valid = 1'b0;
        m_rgb   = 12'h000;
        m_tr    = 1'b0;
    endtask

    function automatic int remap(input int idx);
        int lo, hi;
        lo = int'(bus.cyc_lo);
        hi = int'(bus.cyc_hi);
        if (bus.cyc_en && lo < hi && idx >= lo && idx <= hi)
            return lo + (idx - lo + m_off) % (hi - lo + 1);
        return idx;
    endfunction

    task automatic idle();
        bus.wr_en      = 1'b0;
        bus.wr_bank    = '0;
        bus.wr_idx     = '0;
        bus.wr_rgb     = '0;
        bus.rd_valid   = 1'b0;
        bus.rd_bank    = '0;
        bus.rd_idx     = '0;
        bus.frame_tick = 1'b0;
        bus.transp_en  = 1'b0;
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(m_valid));
        chk({tag, ".rgb"}, 32'({bus.red, bus.green, bus.blue}), 32'(m_rgb));
        chk({tag, ".transp"}, 32'(bus.transparent), 32'(m_tr));
    endtask

    // Advance the model by one clock using the inputs now on the bus.
    task automatic cycle(input string tag);
        int lo, hi;
        if (bus.rd_valid) begin
            m_valid = 1'b1;
            m_rgb   = m_mem[bus.rd_bank][remap(int'(bus.rd_idx))];
            m_tr    = bus.transp_en && (bus.rd_idx == 0);
        end else begin
            m_valid = 1'b0;
        end
        if (bus.wr_en) m_mem[bus.wr_bank][bus.wr_idx] = bus.wr_rgb;
        lo = int'(bus.cyc_lo);
        hi = int'(bus.cyc_hi);
        if (!(bus.cyc_en && lo < hi)) begin
            m_ticks = 0;
            m_off   = 0;
        end else if (bus.frame_tick) begin
            m_ticks++;
            if (m_ticks == CYC_DIV) begin
                m_ticks = 0;
                m_off   = (m_off >= hi - lo) ? 0 : m_off + 1;
            end
        end
        @(posedge Clk);
        #1;
        check_out(tag);
    endtask

    task automatic read(input int b, input int idx, input string tag);
        idle();
        bus.rd_valid = 1'b1;
        bus.rd_bank  = 2'(b);
        bus.rd_idx   = 4'(idx);
        cycle(tag);
        idle();
    endtask

    task automatic write(input int b, input int idx, input logic [11:0] v);
        idle();
        bus.wr_en   = 1'b1;
        bus.wr_bank = 2'(b);
        bus.wr_idx  = 4'(idx);
        bus.wr_rgb  = v;
        cycle("wr");
        idle();
    endtask

    task automatic tick_pair();
        idle();
        bus.frame_tick = 1'b1;
        cycle("tick");
        cycle("tick");
        idle();
    endtask

    logic [11:0] exp_cyc [4];

    initial begin
        Reset = 1'b1;
        idle();
        bus.cyc_en = 1'b0;
        bus.cyc_lo = '0;
        bus.cyc_hi = '0;
        model_reset();
        @(posedge Clk);
        @(posedge Clk);
        #1;
        check_out("reset");
        Reset = 1'b0;

        read(0, 1, "boot1");
        chk("boot1.direct", 32'({bus.red, bus.green, bus.blue}), 32'h520);

        idle();
        bus.wr_en    = 1'b1;
        bus.wr_bank  = 2'd2;
        bus.wr_idx   = 4'd7;
        bus.wr_rgb   = 12'hC3A;
        bus.rd_valid = 1'b1;
        bus.rd_bank  = 2'd2;
        bus.rd_idx   = 4'd7;
        cycle("rfirst");
        chk("rfirst.old", 32'({bus.red, bus.green, bus.blue}), 32'h6AF);
        read(2, 7, "rnext");
        chk("rnext.new", 32'({bus.red, bus.green, bus.blue}), 32'hC3A);

        idle();
        bus.transp_en = 1'b1;
        bus.rd_valid  = 1'b1;
        bus.rd_bank   = 2'd1;
        cycle("transp_on");
        chk("transp_on.key", 32'(bus.transparent), 32'd1);
        bus.transp_en = 1'b0;
        cycle("transp_off");
        chk("transp_off.key", 32'(bus.transparent), 32'd0);
        idle();
        cycle("hold");

        write(0, 4, 12'h111);
        write(0, 5, 12'h222);
        write(0, 6, 12'h333);
        write(0, 7, 12'h444);
        bus.cyc_en = 1'b1;
        bus.cyc_lo = 4'd4;
        bus.cyc_hi = 4'd7;
        exp_cyc[0] = 12'h222;
        exp_cyc[1] = 12'h333;
        exp_cyc[2] = 12'h444;
        exp_cyc[3] = 12'h111;
        for (int k = 0; k < 4; k++) begin
            tick_pair();
            read(0, 4, "cycle");
            chk("cycle.eff", 32'({bus.red, bus.green, bus.blue}), 32'(exp_cyc[k]));
        end

        tick_pair();
        tick_pair();
        read(0, 4, "off2");
        chk("off2.eff", 32'({bus.red, bus.green, bus.blue}), 32'h333);

        idle();
        bus.wr_en   = 1'b1;
        bus.wr_bank = 2'd0;
        bus.wr_idx  = 4'd6;
        bus.wr_rgb  = 12'hABC;
        bus.frame_tick = 1'b1;
        #3;
        Reset = 1'b1;
        #1;
        model_reset();
        check_out("async_rst");
        @(posedge Clk);
        @(posedge Clk);
        #1;
        check_out("in_rst");
        idle();
        #2;
        Reset = 1'b0;
        read(0, 6, "post_rst");
        chk("post_rst.drop", 32'({bus.red, bus.green, bus.blue}), 32'h6AF);
        read(0, 4, "post_rst_off");
        chk("post_rst_off.eff", 32'({bus.red, bus.green, bus.blue}), 32'h000);

        write(0, 5, 12'h555);
        bus.cyc_lo = 4'd9;
        bus.cyc_hi = 4'd3;
        for (int k = 0; k < 3; k++) tick_pair();
        read(0, 5, "inverted");
        chk("inverted.eff", 32'({bus.red, bus.green, bus.blue}), 32'h555);
        bus.cyc_lo = 4'd4;
        bus.cyc_hi = 4'd7;
        read(0, 5, "off_zero");
        chk("off_zero.eff", 32'({bus.red, bus.green, bus.blue}), 32'h555);

        for (int n = 0; n < 800; n++) begin
            if (n % 60 == 0) begin
                bus.cyc_en = ($urandom_range(0, 4) != 0);
                bus.cyc_lo = 4'($urandom_range(0, 15));
                bus.cyc_hi = 4'($urandom_range(0, 15));
            end
            bus.wr_en      = ($urandom_range(0, 3) == 0);
            bus.wr_bank    = 2'($urandom);
            bus.wr_idx     = 4'($urandom);
            bus.wr_rgb     = 12'($urandom);
            bus.rd_valid   = ($urandom_range(0, 2) != 0);
            bus.rd_bank    = 2'($urandom);
            bus.rd_idx     = 4'($urandom);
            bus.frame_tick = ($urandom_range(0, 2) == 0);
            bus.transp_en  = 1'($urandom);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_palette_ram.md
SPRITE_PALETTE_RAM -- requirements
Module: sprite_palette_ram

Interface
REQ-001 SHALL have parameter IDX_W, default 4, colour-index width (2^IDX_W entries per bank).
REQ-002 SHALL have parameter CH_W, default 4, bits per colour channel.
REQ-003 SHALL have parameter NUM_BANKS, default 4, number of independent palettes (power of two, >=1).
REQ-004 SHALL have parameter CYC_DIV, default 8, frame ticks per colour-cycle step (>=1).
REQ-005 SHALL have ports Clk in 1, system clock; Reset in 1, asynchronous active-high reset.
REQ-006 SHALL have ports wr_en in 1, write strobe; wr_bank in clog2(NUM_BANKS), write bank; wr_idx in IDX_W, write entry; wr_rgb in 3*CH_W, {R,G,B} write data.
REQ-007 SHALL have ports rd_valid in 1, lookup request; rd_bank in clog2(NUM_BANKS), lookup bank; rd_idx in IDX_W, pixel index.
REQ-008 SHALL have ports frame_tick in 1, one-cycle pulse per frame; cyc_en in 1, colour-cycle enable; cyc_lo in IDX_W and cyc_hi in IDX_W, inclusive cycled index range; transp_en in 1, treat index 0 as transparent.
REQ-009 SHALL have ports out_valid out 1, lookup result valid; red, green, blue out CH_W each; transparent out 1, pixel is key colour.

Function
REQ-010 Lookup latency SHALL be exactly 1 cycle: out_valid(t+1)=rd_valid(t); red/green/blue/transparent SHALL be registered.
REQ-011 When rd_valid=0, out_valid SHALL be 0 and colour outputs SHALL hold their previous values.
REQ-012 Effective index: if cyc_en=1, cyc_lo<cyc_hi and cyc_lo<=rd_idx<=cyc_hi, eff = cyc_lo + ((rd_idx-cyc_lo+offset) mod (cyc_hi-cyc_lo+1)); otherwise eff = rd_idx.
REQ-013 Remap arithmetic SHALL be done at IDX_W+1 bits; no wrap outside [cyc_lo,cyc_hi].
REQ-014 transparent SHALL be 1 iff transp_en=1 and rd_idx==0 (pre-remap); colour outputs still show the entry.
REQ-015 Write SHALL take effect at the clock edge with wr_en=1; entry readable the following cycle.
REQ-016 Same-cycle read and write of the same bank/entry SHALL return the old value (read-first).
REQ-017 Frame-tick divider SHALL count frame_tick pulses 0..CYC_DIV-1; on the pulse at CYC_DIV-1 it wraps to 0 and offset advances.
REQ-018 offset SHALL advance 0..(cyc_hi-cyc_lo) and wrap to 0; if offset exceeds the span after a range change, it SHALL reset to 0 on the next step.
REQ-019 cyc_en=0, or cyc_lo>=cyc_hi, SHALL clear divider and offset to 0 synchronously and disable remap.
REQ-020 frame_tick coincident with a lookup SHALL NOT affect that lookup; the new offset applies from the next cycle.

Reset
REQ-021 Reset SHALL asynchronously set out_valid=0, transparent=0, red/green/blue=0, divider=0, offset=0.
REQ-022 Reset SHALL load every entry of every bank with the package constant DEFAULT_RGB (12'h6AF for CH_W=4), then entries 1..4 of bank 0 with 5/2/0, F/F/F, 9/4/0, 0/0/0.
REQ-023 Writes and lookups during Reset SHALL be ignored; first lookup after release returns reset contents.

Structure
REQ-024 A shared package SHALL hold rgb_t typedef, DEFAULT_RGB, bank-0 boot table and the clog2 helper.
REQ-025 One sub-module palette_cycle_ctrl SHALL contain divider, offset and remap logic; storage and output registers SHALL stay in the top.

Verification
REQ-026 Reset, then rd_valid=1, bank 0, idx 1 -> next cycle out_valid=1, RGB=5/2/0, transparent=0.
REQ-027 Write bank 2 idx 7 = C/3/A, read same entry same cycle then next cycle -> first result 6/A/F, second C/3/A.
REQ-028 transp_en=1, read idx 0 -> transparent=1, RGB=6/A/F; transp_en=0 -> transparent=0.
REQ-029 cyc_en=1, lo=4, hi=7, CYC_DIV=2, 8 frame ticks, read idx 4 after each pair -> eff index 5,6,7,4.
REQ-030 cyc_lo=9, cyc_hi=3, frame ticks applied -> read idx 5 returns entry 5, offset stays 0.
REQ-031 Assert Reset mid-cycle-run with offset=2 and pending write -> offset 0, write discarded, outputs 0.
